// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: FSM state encoding and the 64-bit pmem line.
package data_mem_responder_pkg;

  localparam int unsigned LineW = 64;
  localparam int unsigned WordW = 32;

  typedef logic [LineW-1:0] line_t;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StWrFill,
    StWrReq,
    StResp
  } dmr_state_t;

  // Select the 32-bit half of a line addressed by byte-address bit 2.
  function automatic logic [WordW-1:0] line_word(line_t line, logic half);
    return half ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_merge.sv
// Combinational byte merge: overlays the enabled bytes of a core word onto one half of a line.
module data_mem_responder_byte_merge
  import data_mem_responder_pkg::*;
(
  input  line_t       line_i,
  input  logic        half_i,
  input  logic [3:0]  mbe_i,
  input  logic [31:0] wdata_i,
  output line_t       merged_o
);

  logic [31:0] word;

  always_comb begin
    word = line_word(line_i, half_i);
    for (int b = 0; b < 4; b++) begin
      if (mbe_i[b]) begin
        word[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end
    merged_o = half_i ? {word, line_i[31:0]} : {line_i[63:32], word};
  end

endmodule

// File: rtl/data_mem_responder.sv
// Core data port to 64-bit pmem bridge with read-modify-write for sub-word stores.
// Define DMR_LINE_BUF_EN to add a one-entry write-through line buffer.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PMEM_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [3:0]        data_mbe,
  input  logic [ADDR_W-1:0] data_mem_address,
  input  logic [31:0]       data_mem_wdata,
  output logic              data_mem_resp,
  output logic [31:0]       data_mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [PMEM_W-1:0] pmem_wdata,
  input  logic [PMEM_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  dmr_state_t        state_q, state_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mbe_q, mbe_d;
  logic              we_q, we_d;
  line_t             line_q, line_d;
  line_t             merged;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^data_mem_address[1:0];

`ifdef DMR_LINE_BUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:3] buf_tag_q, buf_tag_d;
  line_t             buf_data_q, buf_data_d;
  logic              buf_hit;

  assign buf_hit = buf_valid_q && (buf_tag_q == data_mem_address[ADDR_W-1:3]);
`endif

  data_mem_responder_byte_merge u_byte_merge (
    .line_i   (line_q),
    .half_i   (addr_q[2]),
    .mbe_i    (mbe_q),
    .wdata_i  (wdata_q),
    .merged_o (merged)
  );

  assign pmem_address = {addr_q[ADDR_W-1:3], 3'b000};

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mbe_d          = mbe_q;
    we_d           = we_q;
    line_d         = line_q;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_wdata     = '0;
    data_mem_resp  = 1'b0;
    data_mem_rdata = '0;
`ifdef DMR_LINE_BUF_EN
    buf_valid_d    = buf_valid_q;
    buf_tag_d      = buf_tag_q;
    buf_data_d     = buf_data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (data_read || data_write) begin
          addr_d  = data_mem_address[ADDR_W-1:2];
          wdata_d = data_mem_wdata;
          mbe_d   = data_mbe;
          we_d    = data_write;  // read+write together resolves to a write
          if (data_write) begin
            if (data_mbe == 4'b0000) begin
              state_d = StResp;
            end else begin
              state_d = StWrFill;
`ifdef DMR_LINE_BUF_EN
              if (buf_hit) begin
                line_d  = buf_data_q;
                state_d = StWrReq;
              end
`endif
            end
          end else begin
            state_d = StRdReq;
`ifdef DMR_LINE_BUF_EN
            if (buf_hit) begin
              line_d  = buf_data_q;
              state_d = StResp;
            end
`endif
          end
        end
      end
      StRdReq, StWrFill: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          state_d = (state_q == StRdReq) ? StResp : StWrReq;
`ifdef DMR_LINE_BUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = addr_q[ADDR_W-1:3];
          buf_data_d  = pmem_rdata;
`endif
        end
      end
      StWrReq: begin
        pmem_write = 1'b1;
        pmem_wdata = merged;
        if (pmem_resp) begin
          line_d  = merged;
          state_d = StResp;
`ifdef DMR_LINE_BUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = addr_q[ADDR_W-1:3];
          buf_data_d  = merged;
`endif
        end
      end
      StResp: begin
        data_mem_resp  = 1'b1;
        data_mem_rdata = we_q ? 32'h0 : line_word(line_q, addr_q[2]);
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      mbe_q       <= '0;
      we_q        <= 1'b0;
      line_q      <= '0;
`ifdef DMR_LINE_BUF_EN
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mbe_q       <= mbe_d;
      we_q        <= we_d;
      line_q      <= line_d;
`ifdef DMR_LINE_BUF_EN
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed scenarios then random word traffic against a line-level memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_read, data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address, data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  int errors = 0;
  int checks = 0;

  // pmem model state; lines cover byte addresses 0x100..0x17F
  logic [63:0] init_mem [16];
  logic [63:0] pmem_mem [16];
  logic [63:0] ref_mem  [16];
  bit          mem_loaded = 1'b0;
  int          lat = 0;
  int          wait_cnt;
  int          rd_ops = 0;
  int          wr_ops = 0;
  logic [3:0]  pidx;

  // Bench view of the optional line buffer: holds the last line that touched pmem.
  bit          bv = 1'b0;
  logic [3:0]  btag = '0;

  logic [31:0] exp_paddr = '0;
  logic [63:0] exp_wline = '0;

  data_mem_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_read        (data_read),
    .data_write       (data_write),
    .data_mbe         (data_mbe),
    .data_mem_address (data_mem_address),
    .data_mem_wdata   (data_mem_wdata),
    .data_mem_resp    (data_mem_resp),
    .data_mem_rdata   (data_mem_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  assign pidx = pmem_address[6:3];

  // pmem responds lat+1 cycles after it first sees a request
  always @(posedge clk) begin
    if (!rst_n) begin
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      wait_cnt   <= 0;
      if (!mem_loaded) begin
        for (int i = 0; i < 16; i++) pmem_mem[i] <= init_mem[i];
        mem_loaded <= 1'b1;
      end
    end else begin
      pmem_resp <= 1'b0;
      if ((pmem_read || pmem_write) && !pmem_resp) begin
        if (wait_cnt >= lat) begin
          pmem_resp <= 1'b1;
          wait_cnt  <= 0;
          if (pmem_write) begin
            pmem_mem[pidx] <= pmem_wdata;
            wr_ops         <= wr_ops + 1;
          end else begin
            pmem_rdata <= pmem_mem[pidx];
            rd_ops     <= rd_ops + 1;
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("pmem_rw_exclusive", 64'(pmem_read && pmem_write), 64'd0);
      check("resp_not_with_pmem_resp", 64'(data_mem_resp && pmem_resp), 64'd0);
      if (pmem_resp && pmem_write) begin
        check("pmem_waddr", 64'(pmem_address), 64'(exp_paddr));
        check("pmem_wdata", pmem_wdata, exp_wline);
      end
      if (pmem_resp && pmem_read) check("pmem_raddr", 64'(pmem_address), 64'(exp_paddr));
    end
  end

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [3:0] mbe,
                        input logic [31:0] wdata, input int l);
    logic [3:0]  li;
    bit          half, hit, seen;
    logic [63:0] cur, nxt;
    logic [31:0] exp_rdata;
    int          exp_cyc, exp_rd, exp_wr, cyc, rd0, wr0;
    li   = addr[6:3];
    half = addr[2];
    cur  = ref_mem[li];
    nxt  = cur;
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (mbe[b]) nxt[half*32 + b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
`ifdef DMR_LINE_BUF_EN
    hit = bv && (btag == li);
`else
    hit = 1'b0;
`endif
    // Cycles count from the accepting edge to the edge that raises resp.
    if (!wr) begin
      exp_rdata = half ? cur[63:32] : cur[31:0];
      exp_wr    = 0;
      exp_rd    = hit ? 0 : 1;
      exp_cyc   = hit ? 1 : l + 3;
      bv = 1'b1; btag = li;
    end else begin
      exp_rdata = 32'h0;
      if (mbe == 4'b0000) begin
        exp_cyc = 1; exp_rd = 0; exp_wr = 0;
      end else begin
        exp_wr  = 1;
        exp_rd  = hit ? 0 : 1;
        exp_cyc = hit ? l + 3 : 2 * l + 5;
        bv = 1'b1; btag = li;
      end
    end
    exp_paddr = {addr[31:3], 3'b000};
    exp_wline = nxt;
    lat       = l;
    @(posedge clk); #1;
    data_read        = !wr;
    data_write       = wr;
    data_mbe         = mbe;
    data_mem_address = addr;
    data_mem_wdata   = wdata;
    rd0 = rd_ops;
    wr0 = wr_ops;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (data_mem_resp) begin
        seen = 1'b1;
        check("rdata", 64'(data_mem_rdata), 64'(exp_rdata));
      end
    end
    check("resp_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(exp_cyc));
    @(posedge clk); #1;
    data_read  = 1'b0;
    data_write = 1'b0;
    @(negedge clk);
    check("resp_single_pulse", 64'(data_mem_resp), 64'd0);
    check("pmem_reads", 64'(rd_ops - rd0), 64'(exp_rd));
    check("pmem_writes", 64'(wr_ops - wr0), 64'(exp_wr));
    ref_mem[li] = nxt;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_resp"}, 64'(data_mem_resp), 64'd0);
    check({tag, "_rdata"}, 64'(data_mem_rdata), 64'd0);
    check({tag, "_pmem_read"}, 64'(pmem_read), 64'd0);
    check({tag, "_pmem_write"}, 64'(pmem_write), 64'd0);
    check({tag, "_pmem_addr"}, 64'(pmem_address), 64'd0);
    check({tag, "_pmem_wdata"}, pmem_wdata, 64'd0);
  endtask

  initial begin
    int          cyc;
    bit          seen;
    logic [31:0] ra;
    rst_n            = 1'b0;
    data_read        = 1'b0;
    data_write       = 1'b0;
    data_mbe         = '0;
    data_mem_address = '0;
    data_mem_wdata   = '0;
    for (int i = 0; i < 16; i++) begin
      init_mem[i] = {$urandom, $urandom};
      ref_mem[i]  = init_mem[i];
    end
    init_mem[0] = 64'h1122_3344_5566_7788;
    ref_mem[0]  = init_mem[0];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed scenarios
    do_txn(1'b0, 32'h100, 4'b0000, 32'h0, 2);
    do_txn(1'b0, 32'h104, 4'b0000, 32'h0, 2);
    do_txn(1'b1, 32'h106, 4'b1100, 32'hABCD_0000, 1);
    do_txn(1'b1, 32'h110, 4'b0000, 32'h1234_5678, 1);

    // Abort a write while it holds pmem_write
    lat       = 8;
    exp_paddr = 32'h108;
    @(posedge clk); #1;
    data_write       = 1'b1;
    data_mbe         = 4'b1111;
    data_mem_address = 32'h108;
    data_mem_wdata   = 32'hDEAD_BEEF;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (pmem_write) seen = 1'b1;
    end
    check("abort_reached_wrreq", 64'(seen), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("abort");
    data_write = 1'b0;
    bv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_txn(1'b0, 32'h108, 4'b0000, 32'h0, 1);

    // Back-to-back on one line
    do_txn(1'b0, 32'h118, 4'b0000, 32'h0, 0);
    do_txn(1'b1, 32'h11C, 4'b1111, 32'hCAFE_F00D, 0);
    do_txn(1'b0, 32'h11C, 4'b0000, 32'h0, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      ra = 32'h100 + 32'($urandom_range(0, 15)) * 8 + 32'($urandom_range(0, 7));
      do_txn(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom,
             int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) check("final_mem", pmem_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
